// File: rtl/dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : dm_resp
// Purpose  : Data-memory responder for the MEM stage. Accepts one byte-
//            addressed load/store at a time, waits WAIT_CYCLES states, then
//            commits the access and returns a one-cycle response carrying
//            sign/zero-extended load data or a misalignment error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, rising edge
//   rstn         in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   responder can accept (IDLE only)
//   req_we       in   1   1 = store, 0 = load
//   req_addr     in  32   byte address
//   req_size     in   2   00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned in   1   zero-extend loads when 1
//   req_wdata    in  32   right-aligned store data
//   resp_valid   out  1   one-cycle response strobe
//   resp_rdata   out 32   load result, 0 for stores and errors
//   resp_err     out  1   misaligned / reserved-size request
//   busy         out  1   request in flight (pipeline stall)
// ============================================================================
module dm_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         C_DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] C_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic [31:0]         mem [C_DEPTH];

  // Address bits above the word index are deliberately ignored (wrap).
  logic                unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  logic                accept;
  assign accept = req_valid && (state_q == IDLE);

  // --------------------------------------------------------------------------
  // Commit source: with zero wait states the access commits on the accept
  // edge itself, so the live request is used; otherwise the latched copy.
  // --------------------------------------------------------------------------
  logic                src_we, src_uns, src_mis, commit;
  logic [ADDR_W+1:0]   src_addr;
  logic [1:0]          src_size, src_off;
  logic [31:0]         src_wdata;
  logic [ADDR_W-1:0]   src_idx;

  always_comb begin
    src_we    = we_q;
    src_addr  = addr_q;
    src_size  = size_q;
    src_uns   = uns_q;
    src_wdata = wdata_q;
    if (state_q == IDLE) begin
      src_we    = req_we;
      src_addr  = req_addr[ADDR_W+1:0];
      src_size  = req_size;
      src_uns   = req_unsigned;
      src_wdata = req_wdata;
    end
  end

  assign src_idx = src_addr[ADDR_W+1:2];
  assign src_off = src_addr[1:0];
  assign src_mis = (src_size == 2'b11) ||
                   ((src_size == 2'b01) && src_off[0]) ||
                   ((src_size == 2'b10) && (src_off != 2'b00));

  assign commit = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

  // --------------------------------------------------------------------------
  // Store lane steering (little-endian)
  // --------------------------------------------------------------------------
  logic [31:0] wr_lanes;
  logic [3:0]  wr_be;
  logic        mem_we;

  always_comb begin
    wr_lanes = '0;
    wr_be    = '0;
    case (src_size)
      2'b00: begin
        wr_lanes = {4{src_wdata[7:0]}};
        wr_be    = 4'b0001 << src_off;
      end
      2'b01: begin
        wr_lanes = {2{src_wdata[15:0]}};
        wr_be    = src_off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_lanes = src_wdata;
        wr_be    = 4'b1111;
      end
      default: begin
        wr_lanes = '0;
        wr_be    = '0;
      end
    endcase
  end

  // Gated by rstn so an edge that lands inside reset never writes.
  assign mem_we = commit && src_we && !src_mis && rstn;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[src_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction and extension
  // --------------------------------------------------------------------------
  logic [31:0] rd_word, rd_shift, rd_ext;

  assign rd_word  = mem[src_idx];
  assign rd_shift = rd_word >> {src_off, 3'b000};

  always_comb begin
    rd_ext = rd_word;
    case (src_size)
      2'b00:   rd_ext = src_uns ? {24'd0, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = src_uns ? {16'd0, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    // Response registers are zero except in the cycle after a commit.
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    if (commit && !src_we && !src_mis) begin
      resp_rdata_d = rd_ext;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_W+1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (src_mis) begin
            // Errors skip the wait states entirely.
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = C_CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_resp
// Purpose  : Directed self-checking bench for dm_resp. Three instances cover
//            WAIT_CYCLES = 0, 2 and 3; `sel` picks which one a step drives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_resp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  int          sel;

  logic        v0, v2, v3;
  logic        rdy0, rdy2, rdy3;
  logic        rv0, rv2, rv3;
  logic [31:0] rd0, rd2, rd3;
  logic        er0, er2, er3;
  logic        bz0, bz2, bz3;

  logic        s_ready, s_rvalid, s_err, s_busy;
  logic [31:0] s_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign v0 = req_valid && (sel == 0);
  assign v2 = req_valid && (sel == 2);
  assign v3 = req_valid && (sel == 3);

  assign s_ready  = (sel == 0) ? rdy0 : (sel == 2) ? rdy2 : rdy3;
  assign s_rvalid = (sel == 0) ? rv0  : (sel == 2) ? rv2  : rv3;
  assign s_rdata  = (sel == 0) ? rd0  : (sel == 2) ? rd2  : rd3;
  assign s_err    = (sel == 0) ? er0  : (sel == 2) ? er2  : er3;
  assign s_busy   = (sel == 0) ? bz0  : (sel == 2) ? bz2  : bz3;

  dm_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0),
    .busy(bz0));

  dm_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2),
    .busy(bz2));

  dm_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3),
    .busy(bz3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request on the selected instance. shape_ok collects: busy high from
  // accept through the response, and the cycle after the response is idle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic shape_ok);
    int guard;
    @(negedge clk);
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    guard = 0;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat      = 0;
    shape_ok = 1'b1;
    rdata    = 'x;
    err      = 1'bx;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!s_busy) shape_ok = 1'b0;
      if (s_rvalid) begin
        rdata = s_rdata;
        err   = s_err;
        break;
      end
    end
    @(negedge clk);
    if (s_rvalid || s_busy || !s_ready || (s_rdata != 32'd0) || s_err) shape_ok = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        shape_ok;
    do_req(we, addr, size, uns, wdata, rdata, err, lat, shape_ok);
    chk({tag, " rdata"}, rdata, exp_rdata);
    chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy/strobe shape"}, {31'd0, shape_ok}, 32'd1);
  endtask

  initial begin
    int sels [3];
    sels = '{0, 2, 3};
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0; sel = 2;

    // Reset state on every instance.
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      #1;
      chk("reset resp_valid", {31'd0, s_rvalid}, 32'd0);
      chk("reset resp_rdata", s_rdata, 32'd0);
      chk("reset resp_err",   {31'd0, s_err},    32'd0);
      chk("reset busy",       {31'd0, s_busy},   32'd0);
      chk("reset req_ready",  {31'd0, s_ready},  32'd1);
    end
    @(negedge clk); rstn = 1'b1;

    // ---- WAIT_CYCLES = 2 ----
    sel = 2;
    xfer("sw 0x10",        1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 3);
    xfer("lw 0x10",        1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3);
    xfer("sb 0x13",        1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, 32'h0,        1'b0, 3);
    xfer("lw after sb",    1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 3);
    xfer("lb 0x13",        1'b0, 32'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 3);
    xfer("lbu 0x13",       1'b0, 32'h13, 2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0, 3);
    xfer("sh 0x12 1234",   1'b1, 32'h12, 2'b01, 1'b0, 32'h00001234, 32'h0,        1'b0, 3);
    xfer("lh 0x12",        1'b0, 32'h12, 2'b01, 1'b0, 32'h0,        32'h00001234, 1'b0, 3);
    xfer("lw after sh",    1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'h1234BEEF, 1'b0, 3);
    xfer("sh 0x12 F00D",   1'b1, 32'h12, 2'b01, 1'b0, 32'h0000F00D, 32'h0,        1'b0, 3);
    xfer("lh 0x12 neg",    1'b0, 32'h12, 2'b01, 1'b0, 32'h0,        32'hFFFFF00D, 1'b0, 3);
    xfer("lhu 0x12",       1'b0, 32'h12, 2'b01, 1'b1, 32'h0,        32'h0000F00D, 1'b0, 3);
    xfer("lh 0x10",        1'b0, 32'h10, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 3);
    xfer("lb 0x11",        1'b0, 32'h11, 2'b00, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0, 3);
    xfer("lbu 0x11",       1'b0, 32'h11, 2'b00, 1'b1, 32'h0,        32'h000000BE, 1'b0, 3);
    // Misaligned / reserved: skip wait states, no write, zero data.
    xfer("sw 0x11 mis",    1'b1, 32'h11, 2'b10, 1'b0, 32'h00000000, 32'h0,        1'b1, 1);
    xfer("sh 0x13 mis",    1'b1, 32'h13, 2'b01, 1'b0, 32'h00000000, 32'h0,        1'b1, 1);
    xfer("size11 0x10",    1'b0, 32'h10, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 1);
    xfer("lw 0x11 mis",    1'b0, 32'h11, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 1);
    xfer("lw unchanged",   1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hF00DBEEF, 1'b0, 3);

    // ---- WAIT_CYCLES = 0, address wrap ----
    sel = 0;
    xfer("sw 0x1000 wrap", 1'b1, 32'h00001000, 2'b10, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 1);
    xfer("lw 0x0",         1'b0, 32'h00000000, 2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 1);
    xfer("lw 0xFFFFF000",  1'b0, 32'hFFFFF000, 2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 1);

    // Request held valid: accepted, blocked during RESP, accepted again.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    chk("held ready before", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    chk("held resp1 valid",   {31'd0, s_rvalid}, 32'd1);
    chk("held resp1 rdata",   s_rdata, 32'hA5A5A5A5);
    chk("held ready in RESP", {31'd0, s_ready},  32'd0);
    @(negedge clk);
    chk("held gap valid",     {31'd0, s_rvalid}, 32'd0);
    chk("held gap ready",     {31'd0, s_ready},  32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held resp2 valid",   {31'd0, s_rvalid}, 32'd1);
    chk("held resp2 rdata",   s_rdata, 32'hA5A5A5A5);
    @(negedge clk);

    // ---- WAIT_CYCLES = 3, reset mid-flight ----
    sel = 3;
    xfer("sw 0x20 pre",    1'b1, 32'h20, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b0, 4);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("inflight busy", {31'd0, s_busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst resp_valid", {31'd0, s_rvalid}, 32'd0);
    chk("midrst resp_rdata", s_rdata, 32'd0);
    chk("midrst resp_err",   {31'd0, s_err},    32'd0);
    chk("midrst busy",       {31'd0, s_busy},   32'd0);
    chk("midrst req_ready",  {31'd0, s_ready},  32'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    xfer("lw 0x20 retained", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h22222222, 1'b0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder at the far end of the load/store address path; sits in the MEM stage of the pipelined CPU.
- Accepts byte-addressed requests whose address comes from the address adder (rs + offset).
- Performs byte, halfword and word accesses with a fixed, parameterised wait-state count.
- Returns a one-cycle response carrying sign- or zero-extended load data or a misalignment error; the pipeline stalls on `busy`.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between accept and commit (0 allowed, maximum 15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- req_unsigned  input  1  zero-extend load (lbu/lhu) when 1, sign-extend when 0.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned or reserved-size request; valid with resp_valid.
- busy  output  1  request in flight (state != IDLE); used as pipeline stall.

Behaviour:
- **Reset** (rstn low, asynchronous):
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
  - req_ready = 1, both during and after reset.
  - Memory array is not reset.
- **Accept:** on a rising edge with req_valid && req_ready, latch we, addr, size, unsigned and wdata. Inputs are ignored in every other state.
- **Misalignment:** error when size == 11, or size == 01 with addr[0] != 0, or size == 10 with addr[1:0] != 0.
- **Word index:** addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap with no error.
- **FSM IDLE -> WAIT:** on accept when WAIT_CYCLES > 0 and the request is aligned. The counter is loaded with WAIT_CYCLES-1.
- **FSM IDLE -> RESP:** on accept when WAIT_CYCLES == 0, or when the request is misaligned. Misaligned requests skip the wait states.
- **FSM WAIT:**
  - Counter decrements each cycle.
  - When the counter reaches 0, go to RESP and commit the access on that same edge.
  - Store: write the enabled byte lanes (little-endian; byte at offset k maps to bits [8k+7:8k]).
  - Load: register the extended data into resp_rdata.
- **Commit for WAIT_CYCLES == 0:** happens on the accept edge itself.
- **FSM RESP:** resp_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0 during RESP.
- **Latency:** resp_valid is asserted WAIT_CYCLES+1 cycles after the accept edge. Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- **Load extension:**
  - Byte: bit 7 of the selected lane is replicated, or zero-extended if req_unsigned.
  - Half: bit 15 of the selected half is replicated, or zero-extended if req_unsigned.
  - Word: returned as-is; req_unsigned is ignored.
- **Store and error responses:** resp_rdata = 0. Misaligned stores write nothing. resp_err = 0 on every aligned response.
- **Outside RESP:** resp_valid, resp_err and resp_rdata all return to 0.
- **Read-after-write:** a load accepted after a store's response returns the stored data.
- **Reset mid-operation:** the in-flight request is abandoned. A store that has not reached its commit edge is not written. Previously committed contents are retained.

Test Plan:
- **Word round-trip:** reset, WAIT_CYCLES=2. Store word 0xDEADBEEF to addr 0x10, then load word from 0x10. Required:
  - resp_valid is asserted 3 cycles after each accept.
  - The load returns 0xDEADBEEF with resp_err = 0.
  - busy is high from the accept edge through the RESP cycle.
- **Byte lanes and extension:** store byte 0x80 to addr 0x13, then load word, lb and lbu from 0x13. Required:
  - The word load from 0x10 returns 0x80ADBEEF.
  - lb from 0x13 returns 0xFFFFFF80.
  - lbu from 0x13 returns 0x00000080.
- **Halfwords:** store half 0x1234 to 0x12, then load from 0x12. Required:
  - lh returns 0x00001234.
  - The word load from 0x10 returns 0x1234BEEF.
  - Store half 0xF00D, then lh returns 0xFFFFF00D.
- **Misalignment:** request word at 0x11, half at 0x13, and size 11. Required:
  - Each gets resp_err = 1 and resp_rdata = 0, with resp_valid exactly 1 cycle after accept.
  - A subsequent word load from 0x10 shows memory unchanged.
- **Wrap and zero-wait:** WAIT_CYCLES=0. Store 0xA5A5A5A5 to addr 0x00001000 (ADDR_W=10), then load word from 0x0. Required:
  - The load returns 0xA5A5A5A5.
  - resp_valid follows each accept by 1 cycle.
  - req_ready is low in the RESP cycle, so a request held valid is accepted on the next cycle.
- **Reset mid-flight:** WAIT_CYCLES=3. Store 0x11111111 to 0x20, then assert rstn low 1 cycle after accept and release. Required:
  - All outputs read 0 during reset, except req_ready, which reads 1.
  - A following load from 0x20 returns the pre-store contents.
